// File: rtl/binary_stream_packer.sv
// rtl/binary_stream_packer.sv - packs a 1-bit-per-pixel video stream into LSB-first words behind a FWFT FIFO.
// Frame start discards any partial word; line end flushes a zero-padded word marked last.
module binary_stream_packer #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic              in_vs,
    input  logic              in_de,
    input  logic              in_bit,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    output logic              m_sof,
    output logic              overflow
);
    localparam int CW = $clog2(WORD_W);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WORD_W - 1);

    logic              vs_d, vs_q, de_d, bit_d;
    logic [CW-1:0]     cnt;
    logic [WORD_W-1:0] sreg;
    logic              sof_pending;
    logic [AW:0]       wptr, rptr;
    logic [WORD_W+1:0] mem [FIFO_DEPTH];
    logic [WORD_W+1:0] head;

    logic              frame_start, pack, push, pop, wr_en, empty, full;
    logic [WORD_W-1:0] word;

    assign frame_start = vs_d & ~vs_q;
    // Frame start outranks packing so a coincident line-end flush is discarded.
    assign pack  = de_d & EN & ~frame_start;
    assign push  = pack & ((cnt == CNT_MAX) | ~in_de);
    assign word  = sreg | (WORD_W'(bit_d) << cnt);
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = ~empty & m_ready;
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d  <= 1'b0;
            vs_q  <= 1'b0;
            de_d  <= 1'b0;
            bit_d <= 1'b0;
        end else begin
            vs_d  <= in_vs;
            vs_q  <= vs_d;
            de_d  <= in_de;
            bit_d <= in_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (frame_start || !EN || push) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (de_d) begin
            cnt  <= cnt + CW'(1);
            sreg <= word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sof_pending <= 1'b0;
            overflow    <= 1'b0;
        end else if (frame_start) begin
            sof_pending <= 1'b1;
            overflow    <= 1'b0;
        end else if (push) begin
            sof_pending <= 1'b0;
            if (full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: outputs are gated by the empty flag.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= {sof_pending, ~in_de, word};
        end
    end

    assign head     = mem[rptr[AW-1:0]];
    assign m_valid  = ~empty;
    assign m_data   = m_valid ? head[WORD_W-1:0] : '0;
    assign m_last   = m_valid & head[WORD_W];
    assign m_sof    = m_valid & head[WORD_W+1];
endmodule

// File: tb/tb_binary_stream_packer.sv
// tb/tb_binary_stream_packer.sv - directed and randomized bench for binary_stream_packer.
// Expected words come from a line-level model: each line is cut into WORD_W chunks.
module tb_binary_stream_packer;
    localparam int W = 32;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         EN = 1'b1;
    logic         in_vs = 1'b0, in_de = 1'b0, in_bit = 1'b0;
    logic         m_valid, m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         m_last, m_sof, overflow;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    bit rnd_ready = 0;

    logic [W+1:0] exp_q[$];
    logic         pix[0:255];
    bit           sof_m = 0, ovf_m = 0, en_m = 1, sim_pop = 0;

    binary_stream_packer #(.WORD_W(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .EN(EN), .in_vs(in_vs), .in_de(in_de), .in_bit(in_bit),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_sof(m_sof), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted word must match the head of the model queue.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                assert (0) else begin
                    errors++;
                    $error("FAIL pop_unexpected: observed %0h expected none", {m_sof, m_last, m_data});
                end
            end else begin
                assert ({m_sof, m_last, m_data} === exp_q[0]) else begin
                    errors++;
                    $error("FAIL pop_word: observed %0h expected %0h", {m_sof, m_last, m_data}, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push_exp(input logic [W+1:0] e);
        if (exp_q.size() >= DEPTH && !sim_pop) ovf_m = 1;
        else exp_q.push_back(e);
    endtask

    task automatic model_seg(input int start, input int n);
        logic [W-1:0] w;
        if (!en_m) return;
        for (int base = start; base < n; base += W) begin
            w = '0;
            for (int j = 0; j < W && base + j < n; j++) w[j] = pix[base + j];
            push_exp({sof_m, (base + W >= n), w});
            sof_m = 0;
        end
    endtask

    task automatic fill(input int n, input int mode);
        for (int i = 0; i < n; i++)
            pix[i] = (mode == 1) ? 1'b1 : (mode == 2) ? ((i % 2) == 0) : 1'($urandom);
    endtask

    task automatic frame_start();
        sof_m = 1;
        ovf_m = 0;
        in_vs = 1;
        tick();
        in_vs = 0;
        tick();
        tick();
    endtask

    task automatic send_line(input int n, input int vs_idx, input bit pop_end);
        if (vs_idx < 0) model_seg(0, n);
        else begin
            sof_m = 1;
            ovf_m = 0;
            model_seg(vs_idx + 1, n);
        end
        for (int i = 0; i < n; i++) begin
            in_de = 1;
            in_bit = pix[i];
            in_vs = (i == vs_idx);
            tick();
        end
        in_de = 0;
        in_vs = 0;
        if (pop_end) m_ready = 1;
        tick();
        if (pop_end) m_ready = 0;
        tick();
        tick();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        m_ready = 1;
        while ((m_valid || exp_q.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_left"}, exp_q.size(), 0);
        m_ready = 0;
    endtask

    initial begin
        int p0;
        tick();
        tick();
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_sof", m_sof, 0);
        check("rst_ovf", overflow, 0);
        rst = 0;
        tick();

        // 32-pixel alternating line, latency to m_valid
        frame_start();
        fill(32, 2);
        model_seg(0, 32);
        for (int i = 0; i < 32; i++) begin
            in_de = 1;
            in_bit = pix[i];
            tick();
        end
        check("lat_early", m_valid, 0);
        in_de = 0;
        tick();
        check("lat_valid", m_valid, 1);
        check("alt_data", m_data, 32'h5555_5555);
        check("alt_last", m_last, 1);
        check("alt_sof", m_sof, 1);
        tick();
        check("hold_data", m_data, 32'h5555_5555);
        drain("alt");

        // 40-pixel all-ones line
        frame_start();
        m_ready = 1;
        fill(40, 1);
        send_line(40, -1, 0);
        drain("ones");

        // overflow, clear on frame start, push with simultaneous pop
        frame_start();
        for (int l = 0; l < 16; l++) begin
            fill(32, 0);
            send_line(32, -1, 0);
        end
        check("full_no_ovf", overflow, 0);
        fill(32, 0);
        send_line(32, -1, 0);
        check("ovf_set", overflow, 1);
        check("ovf_model", ovf_m, 1);
        frame_start();
        check("ovf_clear", overflow, 0);
        sim_pop = 1;
        fill(32, 0);
        send_line(32, -1, 1);
        sim_pop = 0;
        check("simpop_no_ovf", overflow, 0);
        p0 = pops;
        drain("ovf");
        check("retained", pops - p0, 16);

        // frame start in the middle of a line
        m_ready = 1;
        fill(30, 0);
        send_line(30, 9, 0);
        drain("midvs");

        // EN low for a whole frame while 3 words drain
        frame_start();
        for (int l = 0; l < 3; l++) begin
            fill(20, 0);
            send_line(20, -1, 0);
        end
        p0 = pops;
        EN = 0;
        en_m = 0;
        frame_start();
        m_ready = 1;
        for (int l = 0; l < 3; l++) begin
            fill(40, 0);
            send_line(40, -1, 0);
        end
        check("en0_pops", pops - p0, 3);
        check("en0_valid", m_valid, 0);
        check("en0_ovf", overflow, 0);
        EN = 1;
        en_m = 1;
        m_ready = 0;

        // async reset mid-line with a word queued
        frame_start();
        fill(20, 0);
        send_line(20, -1, 0);
        check("prerst_valid", m_valid, 1);
        for (int i = 0; i < 10; i++) begin
            in_de = 1;
            in_bit = 1'($urandom);
            tick();
        end
        #2 rst = 1;
        #1;
        check("arst_valid", m_valid, 0);
        check("arst_data", m_data, 0);
        check("arst_sof", m_sof, 0);
        in_de = 0;
        exp_q.delete();
        sof_m = 0;
        ovf_m = 0;
        tick();
        tick();
        rst = 0;
        tick();
        check("postrst_valid", m_valid, 0);
        fill(40, 0);
        send_line(40, -1, 0);
        drain("postrst");
        frame_start();
        fill(8, 0);
        send_line(8, -1, 0);
        drain("postrst_sof");

        // randomized frames with random back-pressure
        rnd_ready = 1;
        for (int f = 0; f < 4; f++) begin
            frame_start();
            for (int l = 0; l < 6; l++) begin
                int n;
                case ($urandom_range(0, 3))
                    0: n = 1;
                    1: n = 32;
                    2: n = 64;
                    default: n = $urandom_range(2, 100);
                endcase
                fill(n, 0);
                send_line(n, -1, 0);
            end
        end
        rnd_ready = 0;
        drain("rand");
        check("rand_ovf", overflow, ovf_m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
